// File: rtl/ls_unit.sv
// Byte-serial load/store unit: one byte per memory request, little-endian assembly of
// load results, single-cycle CDB broadcast for loads; accepts a new op only when idle.
`ifndef LS_UNIT_DEFS
`define LS_UNIT_DEFS
`define TagBus   3:0
`define NameBus  4:0
`define OpBus    5:0
`define NOP      6'd0
`define LB       6'd1
`define LH       6'd2
`define LW       6'd3
`define LBU      6'd4
`define LHU      6'd5
`define SB       6'd6
`define SH       6'd7
`define SW       6'd8
`define tagFree  '0
`define dataFree '0
`define nameFree '0
`endif

module ls_unit #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = $bits(logic [`TagBus]),
   parameter int NAME_W = $bits(logic [`NameBus])
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LSworkEn,
   input  logic [DATA_W-1:0] operandO,
   input  logic [DATA_W-1:0] operandT,
   input  logic [DATA_W-1:0] imm,
   input  logic [`OpBus]     opCode,
   input  logic [TAG_W-1:0]  wrtTag,
   input  logic [NAME_W-1:0] wrtName,
   output logic              LSreadEn,
   output logic              memEn,
   output logic              memWr,
   output logic [DATA_W-1:0] memAddr,
   output logic [7:0]        memWdata,
   input  logic [7:0]        memRdata,
   input  logic              memBusy,
   output logic              enLSwrt,
   output logic [TAG_W-1:0]  LStag,
   output logic [DATA_W-1:0] LSdata,
   output logic [NAME_W-1:0] LSname
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [NAME_W-1:0] name_q, name_d;
   logic [`OpBus]     op_q, op_d;
   logic [1:0]        k_q, k_d;
   logic [31:0]       result_q, result_d;

   // Byte count per opcode; zero marks an opcode the unit does not execute.
   function automatic logic [2:0] op_bytes(input logic [`OpBus] op);
      case (op)
         `LB, `LBU, `SB: op_bytes = 3'd1;
         `LH, `LHU, `SH: op_bytes = 3'd2;
         `LW, `SW:       op_bytes = 3'd4;
         default:        op_bytes = 3'd0;
      endcase
   endfunction

   logic       is_store;
   logic [2:0] n_bytes;
   logic       last_byte;

   assign is_store  = (op_q == `SB) || (op_q == `SH) || (op_q == `SW);
   assign n_bytes   = op_bytes(op_q);
   assign last_byte = ({1'b0, k_q} + 3'd1) == n_bytes;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         tag_q    <= '0;
         name_q   <= '0;
         op_q     <= `NOP;
         k_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         tag_q    <= tag_d;
         name_q   <= name_d;
         op_q     <= op_d;
         k_q      <= k_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      tag_d    = tag_q;
      name_d   = name_q;
      op_d     = op_q;
      k_d      = k_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (LSworkEn && (op_bytes(opCode) != 3'd0)) begin
               addr_d   = operandO + imm;
               wdata_d  = operandT;
               tag_d    = wrtTag;
               name_d   = wrtName;
               op_d     = opCode;
               k_d      = 2'd0;
               result_d = '0;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (!memBusy) begin
               if (!is_store) begin
                  state_d = S_WAIT;
               end else if (last_byte) begin
                  state_d = S_IDLE;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
         end
         S_WAIT: begin
            result_d[{k_q, 3'b000} +: 8] = memRdata;
            if (last_byte) begin
               state_d = S_DONE;
            end else begin
               k_d     = k_q + 2'd1;
               state_d = S_REQ;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      LSreadEn = (state_q == S_IDLE);
      memEn    = 1'b0;
      memWr    = 1'b0;
      memAddr  = '0;
      memWdata = '0;
      enLSwrt  = 1'b0;
      LStag    = `tagFree;
      LSdata   = `dataFree;
      LSname   = `nameFree;
      if (state_q == S_REQ) begin
         memEn    = 1'b1;
         memWr    = is_store;
         memAddr  = addr_q + DATA_W'(k_q);
         memWdata = wdata_q[{k_q, 3'b000} +: 8];
      end
      if (state_q == S_DONE) begin
         enLSwrt = 1'b1;
         LStag   = tag_q;
         LSname  = name_q;
         case (op_q)
            `LB:     LSdata = DATA_W'($signed(result_q[7:0]));
            `LH:     LSdata = DATA_W'($signed(result_q[15:0]));
            `LBU:    LSdata = DATA_W'(result_q[7:0]);
            `LHU:    LSdata = DATA_W'(result_q[15:0]);
            default: LSdata = DATA_W'(result_q);
         endcase
      end
   end

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: byte-wide memory model, broadcast monitor, hand-computed expectations.
`timescale 1ns/1ps
module tb_ls_unit;

   localparam logic [5:0] OP_NOP = 6'd0, OP_LB = 6'd1, OP_LH = 6'd2, OP_LW = 6'd3,
                          OP_LBU = 6'd4, OP_LHU = 6'd5, OP_SB = 6'd6, OP_SH = 6'd7, OP_SW = 6'd8;

   logic        clk, rst, LSworkEn, memBusy;
   logic [31:0] operandO, operandT, imm;
   logic [5:0]  opCode;
   logic [3:0]  wrtTag;
   logic [4:0]  wrtName;
   logic        LSreadEn, memEn, memWr, enLSwrt;
   logic [31:0] memAddr, LSdata;
   logic [7:0]  memWdata, memRdata;
   logic [3:0]  LStag;
   logic [4:0]  LSname;

   ls_unit dut (
      .clk(clk), .rst(rst), .LSworkEn(LSworkEn), .operandO(operandO), .operandT(operandT),
      .imm(imm), .opCode(opCode), .wrtTag(wrtTag), .wrtName(wrtName), .LSreadEn(LSreadEn),
      .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .memBusy(memBusy), .enLSwrt(enLSwrt), .LStag(LStag),
      .LSdata(LSdata), .LSname(LSname)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  mem [1024];
   logic [31:0] rd_log[$];
   logic [31:0] wr_addr[$];
   logic [7:0]  wr_dat[$];
   int          bc_cnt = 0;
   time         bc_time;
   logic [31:0] bc_data;
   logic [3:0]  bc_tag;
   logic [4:0]  bc_name;

   always @(posedge clk) begin
      if (memEn && !memBusy) begin
         if (memWr) begin
            wr_addr.push_back(memAddr);
            wr_dat.push_back(memWdata);
         end else begin
            rd_log.push_back(memAddr);
            memRdata <= mem[memAddr[9:0]];
         end
      end
      if (enLSwrt) begin
         bc_cnt  = bc_cnt + 1;
         bc_time = $time;
         bc_data = LSdata;
         bc_tag  = LStag;
         bc_name = LSname;
      end
   end

   int  n_chk = 0, n_pass = 0;
   time t0;
   int  cyc, bc_base, rd_base, wr_base;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic snap();
      bc_base = bc_cnt;
      rd_base = rd_log.size();
      wr_base = wr_addr.size();
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] i, input logic [3:0] tg, input logic [4:0] nm);
      opCode = op; operandO = a; operandT = d; imm = i; wrtTag = tg; wrtName = nm;
      LSworkEn = 1'b1;
      @(posedge clk);
      t0 = $time;
      #1 LSworkEn = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      cyc = 0;
      while (!LSreadEn && cyc < 60) begin
         @(posedge clk);
         #1 cyc++;
      end
      check({tag, "_idle_timeout"}, LSreadEn, 1'b1);
   endtask

   task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [3:0] tg, input logic [4:0] nm, input logic [31:0] exp);
      snap();
      issue(op, a, 32'h0, 32'h0, tg, nm);
      wait_idle(tag);
      check({tag, "_bc_cnt"}, bc_cnt - bc_base, 1);
      check({tag, "_data"}, bc_data, exp);
      check({tag, "_tag"}, bc_tag, tg);
      check({tag, "_name"}, bc_name, nm);
   endtask

   initial begin
      logic [31:0] sw_a [4];
      logic [7:0]  sw_d [4];
      for (int j = 0; j < 1024; j++) mem[j] = 8'h00;
      mem[10'h104] = 8'h11; mem[10'h105] = 8'h22; mem[10'h106] = 8'h33; mem[10'h107] = 8'h44;
      mem[10'h300] = 8'h80; mem[10'h302] = 8'h34; mem[10'h303] = 8'h92;
      mem[10'h100] = 8'h77; mem[10'h101] = 8'h66;
      mem[10'h3FF] = 8'h5A; mem[10'h000] = 8'h01;
      rst = 1'b0; LSworkEn = 1'b0; memBusy = 1'b0; memRdata = 8'h00;
      operandO = '0; operandT = '0; imm = '0; opCode = OP_NOP; wrtTag = '0; wrtName = '0;

      #2;
      check("rst_readen", LSreadEn, 1'b1);
      check("rst_memen", memEn, 1'b0);
      check("rst_memwr", memWr, 1'b0);
      check("rst_memaddr", memAddr, 32'h0);
      check("rst_memwdata", memWdata, 8'h0);
      check("rst_enlswrt", enLSwrt, 1'b0);
      check("rst_tag", LStag, 4'h0);
      check("rst_data", LSdata, 32'h0);
      check("rst_name", LSname, 5'h0);
      #10 rst = 1'b1;
      @(posedge clk); #1;

      // LW from 0x100+4: four byte reads, broadcast in cycle 9
      snap();
      issue(OP_LW, 32'h100, 32'h0, 32'h4, 4'h5, 5'h0C);
      check("lw_req_memen", memEn, 1'b1);
      check("lw_req_memwr", memWr, 1'b0);
      wait_idle("lw");
      check("lw_cycles", cyc, 9);
      check("lw_bc_cycle", (bc_time - t0) / 10, 9);
      check("lw_bc_cnt", bc_cnt - bc_base, 1);
      check("lw_data", bc_data, 32'h44332211);
      check("lw_tag", bc_tag, 4'h5);
      check("lw_name", bc_name, 5'h0C);
      check("lw_nreads", rd_log.size() - rd_base, 4);
      for (int j = 0; j < 4; j++) check("lw_rd_addr", rd_log[rd_base + j], 32'h104 + j);

      do_load("lb", OP_LB, 32'h300, 4'h1, 5'h01, 32'hFFFFFF80);
      do_load("lbu", OP_LBU, 32'h300, 4'h2, 5'h02, 32'h00000080);
      do_load("lh", OP_LH, 32'h302, 4'h3, 5'h03, 32'hFFFF9234);
      do_load("lhu", OP_LHU, 32'h302, 4'h4, 5'h04, 32'h00009234);
      check("lbu_cycles", cyc + 0, cyc);
      do_load("lbu_lat", OP_LBU, 32'h300, 4'h6, 5'h06, 32'h00000080);
      check("lb_latency", cyc, 3);

      // Misaligned SH at 0x201
      snap();
      issue(OP_SH, 32'h200, 32'h0000ABCD, 32'h1, 4'h7, 5'h07);
      check("sh_memwr", memWr, 1'b1);
      wait_idle("sh");
      check("sh_cycles", cyc, 2);
      check("sh_no_bc", bc_cnt - bc_base, 0);
      check("sh_nwr", wr_addr.size() - wr_base, 2);
      check("sh_a0", wr_addr[wr_base], 32'h201);
      check("sh_d0", wr_dat[wr_base], 8'hCD);
      check("sh_a1", wr_addr[wr_base + 1], 32'h202);
      check("sh_d1", wr_dat[wr_base + 1], 8'hAB);

      // SW stalled three cycles on byte 0, address 0x3F0-2
      snap();
      memBusy = 1'b1;
      issue(OP_SW, 32'h3F0, 32'hDEADBEEF, 32'hFFFFFFFE, 4'h8, 5'h08);
      for (int j = 0; j < 3; j++) begin
         check("sw_stall_en", memEn, 1'b1);
         check("sw_stall_addr", memAddr, 32'h3EE);
         check("sw_stall_wdata", memWdata, 8'hEF);
         @(posedge clk); #1;
      end
      memBusy = 1'b0;
      wait_idle("sw");
      check("sw_latency", cyc + 3, 7);
      check("sw_no_bc", bc_cnt - bc_base, 0);
      check("sw_nwr", wr_addr.size() - wr_base, 4);
      sw_a = '{32'h3EE, 32'h3EF, 32'h3F0, 32'h3F1};
      sw_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int j = 0; j < 4; j++) begin
         check("sw_addr", wr_addr[wr_base + j], sw_a[j]);
         check("sw_data", wr_dat[wr_base + j], sw_d[j]);
      end

      // NOP and an undefined opcode are dropped
      snap();
      issue(OP_NOP, 32'h100, 32'h0, 32'h0, 4'h9, 5'h09);
      check("nop_readen", LSreadEn, 1'b1);
      check("nop_memen", memEn, 1'b0);
      issue(6'h3F, 32'h100, 32'h0, 32'h0, 4'h9, 5'h09);
      check("badop_readen", LSreadEn, 1'b1);
      check("badop_memen", memEn, 1'b0);
      @(posedge clk); #1;
      check("badop_no_bc", bc_cnt - bc_base, 0);
      check("badop_no_rd", rd_log.size() - rd_base, 0);

      // Reset during WAIT of an LH
      snap();
      issue(OP_LH, 32'h100, 32'h0, 32'h0, 4'hA, 5'h0A);
      @(posedge clk); #1;
      check("lhrst_wait_memen", memEn, 1'b0);
      check("lhrst_wait_readen", LSreadEn, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("lhrst_readen", LSreadEn, 1'b1);
      check("lhrst_memen", memEn, 1'b0);
      check("lhrst_memaddr", memAddr, 32'h0);
      check("lhrst_enlswrt", enLSwrt, 1'b0);
      check("lhrst_data", LSdata, 32'h0);
      #2 rst = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
      end
      check("lhrst_no_bc", bc_cnt - bc_base, 0);
      do_load("post_rst_lw", OP_LW, 32'h104, 4'hB, 5'h0B, 32'h44332211);

      // Second issue while an LW is in flight is ignored
      snap();
      issue(OP_LW, 32'h104, 32'h0, 32'h0, 4'h3, 5'h13);
      @(posedge clk); #1;
      opCode = OP_SB; operandO = 32'h0; operandT = 32'hFF; wrtTag = 4'h9; wrtName = 5'h19;
      LSworkEn = 1'b1;
      @(posedge clk); #1;
      LSworkEn = 1'b0;
      wait_idle("viol");
      check("viol_bc_cycle", (bc_time - t0) / 10, 9);
      check("viol_bc_cnt", bc_cnt - bc_base, 1);
      check("viol_tag", bc_tag, 4'h3);
      check("viol_name", bc_name, 5'h13);
      check("viol_data", bc_data, 32'h44332211);
      check("viol_no_wr", wr_addr.size() - wr_base, 0);

      // Address wrap at 2^32
      snap();
      do_load("wrap_lhu", OP_LHU, 32'hFFFFFFFF, 4'hC, 5'h1C, 32'h0000015A);
      check("wrap_rd0", rd_log[rd_base], 32'hFFFFFFFF);
      check("wrap_rd1", rd_log[rd_base + 1], 32'h00000000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
